mem_port_arbiter: RTL and testbench

- Shares the single memory data port between two requesters: requester 0 is the CPU load/store path, requester 1 is the debug/loader path.
- Issues at most one memory operation per cycle.
- Arbitrates round-robin, with an optional bounded burst lock.
- Tracks outstanding reads so each returning word is steered back to the requester that issued it.

---
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single memory data port.
// Requester 0 is the CPU load/store path, requester 1 the debug/loader path.
// Round-robin between requesters, with an optional burst lock that is cut
// after MAX_BURST grants whenever the other side is waiting. Read ownership
// rides a RD_LAT-deep tag pipeline aligned with the memory read latency.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner, round-robin between both requesters
// OWN0  | r0 holds the lock, only r0 may be granted
// OWN1  | r1 holds the lock, only r1 may be granted
module mem_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_rw,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic          r0_lock,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_rw,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  input  logic          r1_lock,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_rw,
  output logic [AW-1:0] mem_aout,
  output logic [DW-1:0] mem_dout,
  input  logic [DW-1:0] mem_din,
  output logic          busy
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t            state;
  logic              rr_ptr;      // 1: r1 wins the next conflict
  logic [CW-1:0]     burst_cnt;
  logic              op_vld;      // an accepted op is on the mem_* outputs
  logic [RD_LAT-1:0] tag_vld;
  logic [RD_LAT-1:0] tag_id;
  logic              burst_full;
  logic              g0;
  logic              g1;

  assign burst_full = (burst_cnt == CW'(MAX_BURST));

  // Grant decision: the owner keeps the port unless it drops req or its
  // burst is used up while the other side waits; then the other side wins.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    case (state)
      OWN0: begin
        if (r0_req && !(burst_full && r1_req)) g0 = 1'b1;
        else if (r1_req)                       g1 = 1'b1;
      end
      OWN1: begin
        if (r1_req && !(burst_full && r0_req)) g1 = 1'b1;
        else if (r0_req)                       g0 = 1'b1;
      end
      default: begin
        if (r0_req && r1_req) begin
          g0 = ~rr_ptr;
          g1 = rr_ptr;
        end else begin
          g0 = r0_req;
          g1 = r1_req;
        end
      end
    endcase
  end

  // No grant can be seen while reset is held.
  assign r0_gnt = g0 & reset;
  assign r1_gnt = g1 & reset;

  // Ownership FSM, round-robin pointer and saturating burst counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      burst_cnt <= '0;
    end else if (r0_gnt) begin
      rr_ptr <= 1'b1;
      if (r0_lock) begin
        state <= OWN0;
        if (state == OWN0)
          burst_cnt <= burst_full ? burst_cnt : burst_cnt + CW'(1);
        else
          burst_cnt <= CW'(1);
      end else begin
        state     <= IDLE;
        burst_cnt <= '0;
      end
    end else if (r1_gnt) begin
      rr_ptr <= 1'b0;
      if (r1_lock) begin
        state <= OWN1;
        if (state == OWN1)
          burst_cnt <= burst_full ? burst_cnt : burst_cnt + CW'(1);
        else
          burst_cnt <= CW'(1);
      end else begin
        state     <= IDLE;
        burst_cnt <= '0;
      end
    end else begin
      // No grant means the owner (if any) has released the port.
      state     <= IDLE;
      burst_cnt <= '0;
    end
  end

  // Drive the accepted op onto the memory port; idle cycles read as rw=0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_vld   <= 1'b0;
      mem_rw   <= 1'b0;
      mem_aout <= '0;
      mem_dout <= '0;
    end else begin
      op_vld <= r0_gnt | r1_gnt;
      if (r0_gnt) begin
        mem_rw   <= r0_rw;
        mem_aout <= r0_addr;
        mem_dout <= r0_wdata;
      end else if (r1_gnt) begin
        mem_rw   <= r1_rw;
        mem_aout <= r1_addr;
        mem_dout <= r1_wdata;
      end else begin
        mem_rw <= 1'b0;
      end
    end
  end

  // Read tag pipeline; stage 0 lines up with the cycle the read is driven.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= (r0_gnt & ~r0_rw) | (r1_gnt & ~r1_rw);
      tag_id[0]  <= r1_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  // Capture returning data for the tagged owner; rdata holds between pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      r0_rvalid <= tag_vld[RD_LAT-1] & ~tag_id[RD_LAT-1];
      r1_rvalid <= tag_vld[RD_LAT-1] &  tag_id[RD_LAT-1];
      if (tag_vld[RD_LAT-1] && !tag_id[RD_LAT-1]) r0_rdata <= mem_din;
      if (tag_vld[RD_LAT-1] &&  tag_id[RD_LAT-1]) r1_rdata <= mem_din;
    end
  end

  assign busy = r0_gnt | r1_gnt | op_vld | (|tag_vld);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level round-robin / read-return model.
module tb_mem_port_arbiter;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int RD_LAT    = 3;
  localparam int MAX_BURST = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          r0_req, r0_rw, r0_lock, r0_gnt, r0_rvalid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_req, r1_rw, r1_lock, r1_gnt, r1_rvalid;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic          mem_rw, busy;
  logic [AW-1:0] mem_aout;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] mem_din = '0;

  int vectors     = 0;
  int miscompares = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
    .clock(clock), .reset(reset),
    .r0_req(r0_req), .r0_rw(r0_rw), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_lock(r0_lock), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_rw(r1_rw), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_lock(r1_lock), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_rw(mem_rw), .mem_aout(mem_aout), .mem_dout(mem_dout), .mem_din(mem_din),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Memory contents as a fixed function of address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  // Memory: the word for the address driven RD_LAT-1 cycles ago is on mem_din
  // at the end of the cycle, giving RD_LAT cycles of read latency.
  logic [AW-1:0] hist [0:3];
  initial for (int i = 0; i < 4; i++) hist[i] = '0;
  always @(posedge clock) begin
    #1;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = mem_aout;
    mem_din = mem_word(hist[RD_LAT-1]);
  end

  task automatic set_r0(input logic req, input logic rw, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic lock);
    r0_req = req; r0_rw = rw; r0_addr = addr; r0_wdata = wd; r0_lock = lock;
  endtask

  task automatic set_r1(input logic req, input logic rw, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic lock);
    r1_req = req; r1_rw = rw; r1_addr = addr; r1_wdata = wd; r1_lock = lock;
  endtask

  task automatic idle_all();
    set_r0(1'b0, 1'b0, '0, '0, 1'b0);
    set_r1(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_all();
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    set_r0(1'b1, 1'b0, 32'h44, 32'h1, 1'b1);
    set_r1(1'b1, 1'b1, 32'h48, 32'h2, 1'b1);
    #1;
    vectors++;
    if ({mem_rw, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, busy} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {mem_rw, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, busy});
    end
    vectors++;
    if ({mem_aout, mem_dout, r0_rdata, r1_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %h %h %h %h expected all zero",
               mem_aout, mem_dout, r0_rdata, r1_rdata);
    end
    idle_all();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clock);
    set_r0(1'b1, 1'b0, 32'h10, '0, 1'b0);
    #1;
    vectors++;
    if ({r0_gnt, r1_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_gnt: got %b expected 10", {r0_gnt, r1_gnt});
    end
    for (int c = 1; c <= RD_LAT + 3; c++) begin
      @(negedge clock);
      set_r0(1'b0, 1'b0, '0, '0, 1'b0);
      #1;
      if (c == 1) begin
        vectors++;
        if (mem_rw !== 1'b0 || mem_aout !== 32'h10) begin
          miscompares++;
          $display("FAIL single_issue: got rw=%b addr=%h expected rw=0 addr=10", mem_rw, mem_aout);
        end
      end
      vectors++;
      if ({r0_rvalid, r1_rvalid} !== {(c == RD_LAT + 1), 1'b0}) begin
        miscompares++;
        $display("FAIL single_rvalid: cycle %0d got %b expected %b", c,
                 {r0_rvalid, r1_rvalid}, {(c == RD_LAT + 1), 1'b0});
      end
      if (c == RD_LAT + 1) begin
        vectors++;
        if (r0_rdata !== 32'hDEADBEEF) begin
          miscompares++;
          $display("FAIL single_rdata: got %h expected deadbeef", r0_rdata);
        end
      end
    end
  endtask

  task automatic test_contention();
    do_reset();
    @(negedge clock);
    set_r0(1'b1, 1'b1, 32'h4, 32'h11, 1'b0);
    set_r1(1'b1, 1'b1, 32'h8, 32'h22, 1'b0);
    #1;
    vectors++;
    if ({r0_gnt, r1_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL cont_gnt0: got %b expected 10", {r0_gnt, r1_gnt});
    end
    @(negedge clock);
    set_r0(1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    vectors++;
    if ({r0_gnt, r1_gnt} !== 2'b01 || {mem_rw, mem_aout, mem_dout} !== {1'b1, 32'h4, 32'h11}) begin
      miscompares++;
      $display("FAIL cont_cyc1: got gnt=%b rw=%b addr=%h data=%h expected 01 1 4 11",
               {r0_gnt, r1_gnt}, mem_rw, mem_aout, mem_dout);
    end
    @(negedge clock);
    set_r1(1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    vectors++;
    if ({r0_gnt, r1_gnt} !== 2'b00 || {mem_rw, mem_aout, mem_dout} !== {1'b1, 32'h8, 32'h22}) begin
      miscompares++;
      $display("FAIL cont_cyc2: got gnt=%b rw=%b addr=%h data=%h expected 00 1 8 22",
               {r0_gnt, r1_gnt}, mem_rw, mem_aout, mem_dout);
    end
    @(negedge clock);
    #1;
    vectors++;
    if ({mem_rw, mem_aout, mem_dout} !== {1'b0, 32'h8, 32'h22}) begin
      miscompares++;
      $display("FAIL cont_after: got rw=%b addr=%h data=%h expected 0 8 22", mem_rw, mem_aout, mem_dout);
    end
  endtask

  task automatic test_burst_lock();
    int  n1;
    logic e0, e1;
    n1 = 0;
    do_reset();
    for (int c = 0; c < 18; c++) begin
      @(negedge clock);
      if (n1 < 12) set_r1(1'b1, 1'b0, AW'(32'h100 + n1 * 4), '0, 1'b1);
      else         set_r1(1'b0, 1'b0, '0, '0, 1'b0);
      if (c >= 1)  set_r0(1'b1, 1'b0, 32'h200, '0, 1'b0);
      #1;
      e1 = (c <= 7) || (c >= 9 && c <= 12);
      e0 = (c == 8) || (c >= 13);
      vectors++;
      if ({r0_gnt, r1_gnt} !== {e0, e1}) begin
        miscompares++;
        $display("FAIL burst_gnt: cycle %0d got %b expected %b", c, {r0_gnt, r1_gnt}, {e0, e1});
      end
      if (r1_gnt) n1++;
    end
    idle_all();
  endtask

  task automatic test_pipelined_reads();
    int   i0, i1, src;
    logic e0, e1, v0, v1;
    i0 = 0;
    i1 = 0;
    do_reset();
    for (int c = 0; c < RD_LAT + 11; c++) begin
      @(negedge clock);
      if (i0 < 4) set_r0(1'b1, 1'b0, AW'(2 * i0), '0, 1'b0);
      else        set_r0(1'b0, 1'b0, '0, '0, 1'b0);
      if (i1 < 4) set_r1(1'b1, 1'b0, AW'(2 * i1 + 1), '0, 1'b0);
      else        set_r1(1'b0, 1'b0, '0, '0, 1'b0);
      #1;
      e0 = (c < 8) && (c % 2 == 0);
      e1 = (c < 8) && (c % 2 == 1);
      vectors++;
      if ({r0_gnt, r1_gnt} !== {e0, e1}) begin
        miscompares++;
        $display("FAIL pipe_gnt: cycle %0d got %b expected %b", c, {r0_gnt, r1_gnt}, {e0, e1});
      end
      src = c - RD_LAT - 1;
      v0 = (src >= 0) && (src < 8) && (src % 2 == 0);
      v1 = (src >= 0) && (src < 8) && (src % 2 == 1);
      vectors++;
      if ({r0_rvalid, r1_rvalid} !== {v0, v1}) begin
        miscompares++;
        $display("FAIL pipe_rvalid: cycle %0d got %b expected %b", c, {r0_rvalid, r1_rvalid}, {v0, v1});
      end
      if (v0 || v1) begin
        vectors++;
        if ((v0 ? r0_rdata : r1_rdata) !== mem_word(AW'(src))) begin
          miscompares++;
          $display("FAIL pipe_rdata: cycle %0d got %h expected %h", c,
                   v0 ? r0_rdata : r1_rdata, mem_word(AW'(src)));
        end
      end
      if (r0_gnt) i0++;
      if (r1_gnt) i1++;
    end
    idle_all();
  endtask

  task automatic test_reset_midop();
    do_reset();
    @(negedge clock);
    set_r0(1'b1, 1'b0, 32'h20, '0, 1'b0);
    @(negedge clock);
    set_r0(1'b0, 1'b0, '0, '0, 1'b0);
    set_r1(1'b1, 1'b0, 32'h24, '0, 1'b0);
    @(negedge clock);
    set_r1(1'b0, 1'b0, '0, '0, 1'b0);
    reset = 1'b0;
    #1;
    vectors++;
    if ({mem_rw, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, busy} !== 6'b0 || mem_aout !== '0) begin
      miscompares++;
      $display("FAIL midop_reset: got ctrl=%b addr=%h expected 000000 0",
               {mem_rw, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, busy}, mem_aout);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      #1;
      vectors++;
      if ({r0_rvalid, r1_rvalid, busy} !== 3'b000) begin
        miscompares++;
        $display("FAIL midop_after: cycle %0d got rvalid/busy=%b expected 000", c,
                 {r0_rvalid, r1_rvalid, busy});
      end
    end
  endtask

  task automatic test_idle();
    idle_all();
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      #1;
      vectors++;
      if ({mem_rw, busy, r0_gnt, r1_gnt} !== 4'b0000) begin
        miscompares++;
        $display("FAIL idle: cycle %0d got rw/busy/gnt=%b expected 0000", c,
                 {mem_rw, busy, r0_gnt, r1_gnt});
      end
    end
  endtask

  typedef struct {
    int            cyc;
    logic          id;
    logic [DW-1:0] data;
  } ret_t;

  task automatic test_random();
    logic          p0, p1, rw0, rw1, e0, e1, x0, x1, last, prev_acc, prev_rw, eb;
    logic [AW-1:0] a0, a1, prev_a;
    logic [DW-1:0] d0, d1, prev_d, xd, hold0, hold1;
    ret_t          q[$];
    ret_t          r;
    p0 = 1'b0; p1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    last = 1'b1;
    prev_acc = 1'b0; prev_rw = 1'b0; prev_a = '0; prev_d = '0;
    hold0 = '0; hold1 = '0; xd = '0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (!p0 && $urandom_range(0, 1) == 1) begin
        p0 = 1'b1; rw0 = 1'($urandom_range(0, 1));
        a0 = AW'($urandom_range(0, 255)); d0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 1) == 1) begin
        p1 = 1'b1; rw1 = 1'($urandom_range(0, 1));
        a1 = AW'($urandom_range(0, 255)); d1 = $urandom;
      end
      set_r0(p0, rw0, a0, d0, 1'b0);
      set_r1(p1, rw1, a1, d1, 1'b0);
      #1;
      if (p0 && p1) begin
        e0 = last;
        e1 = ~last;
      end else begin
        e0 = p0;
        e1 = p1;
      end
      vectors++;
      if ({r0_gnt, r1_gnt} !== {e0, e1}) begin
        miscompares++;
        $display("FAIL rnd_gnt: cycle %0d got %b expected %b", c, {r0_gnt, r1_gnt}, {e0, e1});
      end
      vectors++;
      if (mem_rw !== (prev_acc ? prev_rw : 1'b0)) begin
        miscompares++;
        $display("FAIL rnd_mem_rw: cycle %0d got %b expected %b", c, mem_rw, prev_acc ? prev_rw : 1'b0);
      end
      if (prev_acc) begin
        vectors++;
        if (mem_aout !== prev_a || mem_dout !== prev_d) begin
          miscompares++;
          $display("FAIL rnd_mem_op: cycle %0d got %h/%h expected %h/%h", c,
                   mem_aout, mem_dout, prev_a, prev_d);
        end
      end
      x0 = 1'b0;
      x1 = 1'b0;
      if (q.size() > 0 && q[0].cyc == c) begin
        x0 = ~q[0].id;
        x1 = q[0].id;
        xd = q[0].data;
        void'(q.pop_front());
      end
      if (x0) hold0 = xd;
      if (x1) hold1 = xd;
      vectors++;
      if ({r0_rvalid, r1_rvalid} !== {x0, x1}) begin
        miscompares++;
        $display("FAIL rnd_rvalid: cycle %0d got %b expected %b", c, {r0_rvalid, r1_rvalid}, {x0, x1});
      end
      vectors++;
      if (r0_rdata !== hold0 || r1_rdata !== hold1) begin
        miscompares++;
        $display("FAIL rnd_rdata: cycle %0d got %h/%h expected %h/%h", c,
                 r0_rdata, r1_rdata, hold0, hold1);
      end
      eb = e0 | e1 | prev_acc | (q.size() > 0);
      vectors++;
      if (busy !== eb) begin
        miscompares++;
        $display("FAIL rnd_busy: cycle %0d got %b expected %b", c, busy, eb);
      end
      prev_acc = e0 | e1;
      if (e0) begin
        prev_rw = rw0; prev_a = a0; prev_d = d0;
        if (!rw0) begin
          r.cyc = c + RD_LAT + 1; r.id = 1'b0; r.data = mem_word(a0);
          q.push_back(r);
        end
        p0 = 1'b0;
        last = 1'b0;
      end
      if (e1) begin
        prev_rw = rw1; prev_a = a1; prev_d = d1;
        if (!rw1) begin
          r.cyc = c + RD_LAT + 1; r.id = 1'b1; r.data = mem_word(a1);
          q.push_back(r);
        end
        p1 = 1'b0;
        last = 1'b1;
      end
    end
    idle_all();
  endtask

  initial begin
    idle_all();
    #2 reset = 1'b0;
    test_reset();
    test_single_read();
    test_contention();
    test_burst_lock();
    test_pipelined_reads();
    test_reset_midop();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
